// File: rtl/mw_adder_pkg.sv
// mw_adder_pkg: shared constants and types for the multi-word adder sequencer
package mw_adder_pkg;
  localparam int SLICE_W = 16;
  localparam logic [2:0] OP_SADD = 3'b000;
  localparam logic [2:0] OP_UADD = 3'b001;
  localparam logic [2:0] OP_SSUB = 3'b010;
  localparam logic [2:0] OP_USUB = 3'b011;
  localparam logic [2:0] OP_INC  = 3'b100;
  localparam logic [2:0] OP_DEC  = 3'b101;
  localparam logic [2:0] ADD_S = 3'b000;
  localparam logic [2:0] ADD_U = 3'b001;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic is_signed(input logic [2:0] code);
    return !(code == OP_UADD || code == OP_USUB);
  endfunction
endpackage

// File: rtl/mw_adder_seq_if.sv
// mw_adder_seq_if: request/response handshake bundle of the multi-word adder sequencer
interface mw_adder_seq_if import mw_adder_pkg::*; #(parameter int NUM_WORDS = 4);
  localparam int W = SLICE_W * NUM_WORDS;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [2:0]   op_code;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;
  logic         zero;
  modport master (output in_valid, op_a, op_b, op_code, out_ready,
                  input in_ready, out_valid, result, carry, overflow, zero);
  modport slave (input in_valid, op_a, op_b, op_code, out_ready,
                 output in_ready, out_valid, result, carry, overflow, zero);
endinterface

// File: rtl/mw_operand_xlate.sv
// mw_operand_xlate: selects slice k of the operands and maps B/cin0 so every op becomes an add
module mw_operand_xlate import mw_adder_pkg::*; #(parameter int NUM_WORDS = 4) (
  input  logic [SLICE_W*NUM_WORDS-1:0] a,
  input  logic [SLICE_W*NUM_WORDS-1:0] b,
  input  logic [2:0]                   op_code,
  input  logic [$clog2(NUM_WORDS)-1:0] k,
  output logic [SLICE_W-1:0]           a_s,
  output logic [SLICE_W-1:0]           b_s,
  output logic                         cin0
);
  logic [SLICE_W-1:0] b_k;
  logic is_add, is_inc, is_dec;
  assign a_s = a[SLICE_W*k +: SLICE_W];
  assign b_k = b[SLICE_W*k +: SLICE_W];
  assign is_add = op_code[2:1] == 2'b00;
  assign is_inc = op_code == OP_INC;
  assign is_dec = op_code == OP_DEC;
  assign b_s = is_add ? b_k : is_inc ? '0 : is_dec ? '1 : ~b_k;
  assign cin0 = !is_add && !is_dec;
endmodule

// File: rtl/mw_adder_seq.sv
// mw_adder_seq: multi-word add/sub sequencer driving an external 16-bit adder one slice per cycle
// Optional `SATURATE_EN clamps signed overflowing results to the signed min/max.
module mw_adder_seq import mw_adder_pkg::*; #(parameter int NUM_WORDS = 4) (
  input  logic               clk,
  input  logic               rst_n,
  mw_adder_seq_if.slave      bus,
  output logic [SLICE_W-1:0] add_a,
  output logic [SLICE_W-1:0] add_b,
  output logic [2:0]         add_code,
  output logic               add_cin,
  output logic               add_coe,
  input  logic [SLICE_W-1:0] add_c,
  input  logic               add_cout,
  input  logic               add_vout
);
  localparam int W = SLICE_W * NUM_WORDS;
  localparam int KW = $clog2(NUM_WORDS);
  localparam logic [KW-1:0] K_TOP = KW'(NUM_WORDS - 1);
  state_t state;
  logic [W-1:0] a_r, b_r, res_nx, res_fin;
  logic [2:0] code_r;
  logic [KW-1:0] k;
  logic cy, cin0, top, sgn, ovf;
  mw_operand_xlate #(.NUM_WORDS(NUM_WORDS)) u_xlate (
    .a(a_r), .b(b_r), .op_code(code_r), .k(k), .a_s(add_a), .b_s(add_b), .cin0(cin0)
  );
  assign top = k == K_TOP;
  assign sgn = is_signed(code_r);
  assign add_code = top && sgn ? ADD_S : ADD_U;
  assign add_cin = k == '0 ? cin0 : cy;
  assign add_coe = 1'b0;
  assign ovf = sgn & add_vout;
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  always_comb begin
    res_nx = bus.result;
    res_nx[SLICE_W*k +: SLICE_W] = add_c;
`ifdef SATURATE_EN
    res_fin = ovf ? {a_r[W-1], {(W-1){~a_r[W-1]}}} : res_nx;
`else
    res_fin = res_nx;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      a_r          <= '0;
      b_r          <= '0;
      code_r       <= OP_UADD;
      k            <= '0;
      cy           <= 1'b0;
      bus.result   <= '0;
      bus.carry    <= 1'b0;
      bus.overflow <= 1'b0;
      bus.zero     <= 1'b0;
    end else
      case (state)
        IDLE: if (bus.in_valid) begin
          state  <= RUN;
          a_r    <= bus.op_a;
          b_r    <= bus.op_b;
          code_r <= bus.op_code;
          k      <= '0;
        end
        RUN: begin
          cy         <= add_cout;
          bus.result <= top ? res_fin : res_nx;
          if (top) begin
            state        <= DONE;
            bus.carry    <= add_cout;
            bus.overflow <= ovf;
            bus.zero     <= res_fin == '0;
          end else
            k <= k + 1'b1;
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_mw_adder_seq.sv
// tb_mw_adder_seq: vector table, corner sequences and random ops against an arithmetic reference
module tb_mw_adder_seq;
  import mw_adder_pkg::*;
  localparam int NW = 4;
  localparam int W = 16 * NW;
`ifdef SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam logic [W-1:0] ONES = '1;
  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [15:0] add_a, add_b, add_c;
  logic [2:0] add_code;
  logic add_cin, add_coe, add_cout, add_vout;
  int checks = 0;
  int failures = 0;

  mw_adder_seq_if #(.NUM_WORDS(NW)) bus ();
  mw_adder_seq #(.NUM_WORDS(NW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .add_a(add_a), .add_b(add_b), .add_code(add_code), .add_cin(add_cin), .add_coe(add_coe),
    .add_c(add_c), .add_cout(add_cout), .add_vout(add_vout)
  );

  always #5 clk = ~clk;

  // combinational adder16 stand-in
  always_comb begin
    {add_cout, add_c} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};
    add_vout = add_code == 3'b000 && add_a[15] == add_b[15] && add_c[15] != add_a[15];
  end

  typedef struct {
    string        nm;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   code;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
  } vec_t;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // mathematical reference: exact signed/unsigned values, then wrap and range-check
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] code,
                       output logic [W-1:0] r, output logic c, output logic v, output logic z);
    logic signed [W+1:0] sa, sb, t, hi, lo;
    sa = {{2{a[W-1]}}, a};
    sb = {{2{b[W-1]}}, b};
    hi = {2'b00, SMAX};
    lo = {2'b11, SMIN};
    if (code == OP_SADD || code == OP_UADD) begin
      t = sa + sb;
      c = ({1'b0, a} + {1'b0, b}) > {1'b0, ONES};
    end else if (code == OP_INC) begin
      t = sa + 1;
      c = a == ONES;
    end else if (code == OP_DEC) begin
      t = sa - 1;
      c = a != '0;
    end else begin
      t = sa - sb;
      c = a >= b;
    end
    r = t[W-1:0];
    v = !(code == OP_UADD || code == OP_USUB) && (t > hi || t < lo);
    if (SAT && v) r = t > hi ? SMAX : SMIN;
    z = r == '0;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] code,
                       output logic [W-1:0] r, output logic c, output logic v, output logic z,
                       output int lat);
    int n;
    bus.op_a = a;
    bus.op_b = b;
    bus.op_code = code;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    r = bus.result;
    c = bus.carry;
    v = bus.overflow;
    z = bus.zero;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[9];
    logic [W-1:0] r, er, a, b;
    logic c, v, z, ec, ev, ez;
    logic [2:0] code;
    int lat, n;

    vt[0] = '{"uadd_carry16", 64'h0000_0000_0000_FFFF, 64'h1, OP_UADD, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0};
    vt[1] = '{"sadd_ovf", SMAX, 64'h1, OP_SADD, SAT ? SMAX : SMIN, 1'b0, 1'b1, 1'b0};
    vt[2] = '{"usub_borrow", 64'h0, 64'h1, OP_USUB, ONES, 1'b0, 1'b0, 1'b0};
    vt[3] = '{"ssub_zero", 64'h5, 64'h5, OP_SSUB, 64'h0, 1'b1, 1'b0, 1'b1};
    vt[4] = '{"dec_borrow", 64'h0001_0000_0000_0000, 64'h1234, OP_DEC, 64'h0000_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vt[5] = '{"inc_wrap", ONES, 64'hABCD, OP_INC, 64'h0, 1'b1, 1'b0, 1'b1};
    vt[6] = '{"op110_ovf", SMIN, 64'h1, 3'b110, SAT ? SMIN : SMAX, 1'b1, 1'b1, 1'b0};
    vt[7] = '{"op111_neg", 64'h3, 64'h5, 3'b111, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vt[8] = '{"dec_ovf", SMIN, 64'h0, OP_DEC, SAT ? SMIN : SMAX, 1'b1, 1'b1, 1'b0};

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.op_code = '0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_flags", {bus.carry, bus.overflow, bus.zero}, 0);
    chk("rst_add_ab", {add_a, add_b}, 0);
    chk("rst_add_code", add_code, 3'b001);
    chk("rst_add_cin_coe", {add_cin, add_coe}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      do_op(vt[i].a, vt[i].b, vt[i].code, r, c, v, z, lat);
      chk({vt[i].nm, "_latency"}, lat, NW);
      chk({vt[i].nm, "_result"}, r, vt[i].r);
      chk({vt[i].nm, "_carry"}, c, vt[i].c);
      chk({vt[i].nm, "_overflow"}, v, vt[i].v);
      chk({vt[i].nm, "_zero"}, z, vt[i].z);
    end

    // backpressure with a second request waiting
    bus.out_ready = 1'b0;
    bus.op_a = 64'd100;
    bus.op_b = 64'd23;
    bus.op_code = OP_UADD;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.op_a = 64'd7;
    bus.op_b = 64'd8;
    bus.op_code = OP_SADD;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_latency", n, NW);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_result", bus.result, 64'd123);
      chk("bp_hold_flags", {bus.carry, bus.overflow, bus.zero}, 0);
      chk("bp_hold_valid_ready", {bus.out_valid, bus.in_ready}, 2'b10);
      @(posedge clk);
      @(negedge clk);
    end
    chk("bp_still_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_after_hs", {bus.out_valid, bus.in_ready}, 2'b01);
    @(posedge clk);
    @(negedge clk);
    chk("bp_second_accepted", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_second_result", bus.result, 64'd15);
    @(posedge clk);
    @(negedge clk);

    // reset in the middle of a sequence
    bus.op_a = SMAX;
    bus.op_b = 64'h1;
    bus.op_code = OP_SADD;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_out_valid", bus.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) n++;
    end
    chk("abort_no_output", n, 0);
    do_op(64'd1, 64'd2, OP_UADD, r, c, v, z, lat);
    chk("abort_next_result", r, 64'd3);
    chk("abort_next_flags", {c, v, z}, 0);

    // random ops with occasional extreme operands
    for (int i = 0; i < 150; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: a = SMAX;
        1: a = SMIN;
        2: b = ONES;
        3: b = a;
        default: ;
      endcase
      code = 3'($urandom_range(0, 7));
      model(a, b, code, er, ec, ev, ez);
      do_op(a, b, code, r, c, v, z, lat);
      chk("rand_result", r, er);
      chk("rand_carry", c, ec);
      chk("rand_overflow", v, ev);
      chk("rand_zero", z, ez);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
